otter_mem_arbiter: RTL and testbench
====================================

// Module: otter_mem_arbiter
// PURPOSE
//  Shares one single-ported memory between instruction fetch (IF, read-only) and the MEM stage (DM, load/store).
//  Sits between the pipeline and the memory backend; one transaction is outstanding at a time.
//  Drives per-requester stalls so the pipeline freezes until its access completes.
//  Data is preferred over fetch; a starvation counter guarantees forward progress for fetch.
// PARAMETERS
//  STARVE_LIMIT  4   consecutive DM grants while IF waits before IF is forced to win; 0 = strict DM priority
// PORTS
//  CLK         in   1   clock
//  RST         in   1   reset, synchronous, active-high
//  if_req      in   1   fetch request; held with if_addr stable until if_valid
//  if_addr     in   32  fetch byte address
//  if_rdata    out  32  fetched word; valid when if_valid
//  if_valid    out  1   one-cycle completion pulse for IF
//  if_stall    out  1   if_req & ~if_valid (combinational)
//  dm_req      in   1   data request; held with dm_* stable until dm_valid
//  dm_we       in   1   1 = store, 0 = load
//  dm_addr     in   32  data byte address
//  dm_wdata    in   32  store data
//  dm_size     in   2   00 byte, 01 half, 10 word; passed through
//  dm_rdata    out  32  load data; valid when dm_valid & ~dm_we
//  dm_valid    out  1   one-cycle completion pulse for DM (loads and stores)
//  dm_stall    out  1   dm_req & ~dm_valid (combinational)
//  mem_req     out  1   backend request; held high until mem_ack sampled
//  mem_we      out  1   backend write enable
//  mem_addr    out  32  backend address
//  mem_wdata   out  32  backend write data
//  mem_size    out  2   backend access size (10 for IF)
//  mem_ack     in   1   backend completion; may be high in first mem_req cycle
//  mem_rdata   in   32  backend read data, valid with mem_ack
// BEHAVIOUR
//  Reset: state IDLE, starve_cnt=0; all outputs 0 (mem_req, mem_we, valids, rdata regs, mem_addr/wdata/size).
//  FSM states IDLE, BUSY_IF, BUSY_DM.
//   IDLE: evaluate at edge; grant DM if dm_req and not forced-IF; else IF if if_req; else stay.
//     Forced-IF: STARVE_LIMIT!=0 & starve_cnt==STARVE_LIMIT & if_req.
//     On grant, latch addr/we/wdata/size into mem_* regs; mem_req=1 from next cycle.
//   BUSY_x: mem_* held constant; on edge sampling mem_ack=1 -> capture mem_rdata, pulse x_valid
//     for the following cycle, mem_req=0, return IDLE. No grant in the pulse cycle (min 1 idle cycle).
//  Latency: request sampled at edge k, ack in first mem_req cycle -> x_valid high cycle after edge k+1.
//  starve_cnt: +1 on each DM grant with if_req high (saturates at STARVE_LIMIT);
//   cleared on IF grant or on DM grant with if_req low.
//  dm_rdata updated only on load completion; stores leave it unchanged. if_rdata updated on IF completion.
//  Simultaneous if_req & dm_req in IDLE: DM wins unless forced-IF.
//  Requester deasserting req mid-transaction: transaction completes, valid still pulses, data kept.
//  Reset mid-transaction: abandon; next cycle mem_req=0, IDLE, no valid pulse.
//  Backend must tolerate an abandoned request.
//  mem_ack while IDLE: ignored.
// TESTING
//  1 IF only, addr 0x100, ack immediate, rdata 0x00000013 -> mem_req 1 cycle, if_valid next cycle, if_rdata=0x13.
//  2 if_req & dm_req load same cycle (0x100 / 0x2000) -> mem_addr 0x2000 first, then 0x100 after 1 idle cycle.
//  3 STARVE_LIMIT=2, both req held, dm re-requests each completion -> grant order DM,DM,IF,DM,DM,IF.
//  4 Store 0xDEADBEEF @0x2004 size 10, ack after 3 waits -> mem_we/wdata stable 4 cycles; one dm_valid; dm_rdata unchanged.
//  5 RST during BUSY_DM -> next cycle mem_req=0, no dm_valid, starve_cnt=0; fresh IF request serviced normally.
//  6 if_req drops after grant -> transaction completes, if_valid pulses once, FSM idles with no new mem_req.

Source files
------------

// File: rtl/otter_mem_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the MEM stage.
// Data wins ties; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module otter_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [1:0]  dm_size,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        dm_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY_IF = 2'd1;
  localparam logic [1:0] ST_BUSY_DM = 2'd2;

  localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [1:0]    state;
  logic [CW-1:0] starve_cnt;
  logic          forced_if;
  logic          in_pulse;
  logic          grant_dm;
  logic          grant_if;

  assign if_stall = if_req & ~if_valid;
  assign dm_stall = dm_req & ~dm_valid;

  // The requester still holds req during its valid pulse, so granting then would repeat it.
  assign in_pulse  = if_valid | dm_valid;
  assign forced_if = (STARVE_LIMIT != 0) && (starve_cnt == LIMIT) && if_req;
  assign grant_dm  = (state == ST_IDLE) && !in_pulse && dm_req && !forced_if;
  assign grant_if  = (state == ST_IDLE) && !in_pulse && if_req && !grant_dm;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_size   <= '0;
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_dm) begin
            state     <= ST_BUSY_DM;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_size  <= dm_size;
            if (!if_req)
              starve_cnt <= '0;
            else if (starve_cnt != LIMIT)
              starve_cnt <= starve_cnt + 1'b1;
          end else if (grant_if) begin
            state      <= ST_BUSY_IF;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            mem_size   <= 2'b10;
            starve_cnt <= '0;
          end
        end
        ST_BUSY_IF: begin
          if (mem_ack) begin
            state    <= ST_IDLE;
            mem_req  <= 1'b0;
            if_rdata <= mem_rdata;
            if_valid <= 1'b1;
          end
        end
        ST_BUSY_DM: begin
          if (mem_ack) begin
            state    <= ST_IDLE;
            mem_req  <= 1'b0;
            dm_valid <= 1'b1;
            if (!mem_we)
              dm_rdata <= mem_rdata;
          end
        end
        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed bench for otter_mem_arbiter with a latency-programmable backend model
// and grant/completion scoreboards.
module tb_otter_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [1:0]  dm_size;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        dm_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  otter_mem_arbiter #(.STARVE_LIMIT(2)) dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_size(dm_size), .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : ((a ^ 32'h5A5A_0000) + 32'h11);
  endfunction

  // Backend: acks after ack_delay wait cycles; ack_force injects a stray ack.
  int   ack_delay = 0;
  int   wait_cnt  = 0;
  logic ack_force = 1'b0;
  assign mem_ack   = ack_force | (mem_req && (wait_cnt == ack_delay));
  assign mem_rdata = mem_word(mem_addr);
  always @(posedge CLK) begin
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
  } grant_t;
  typedef struct {
    logic        is_dm;
    logic [31:0] data;
  } done_t;

  grant_t exp_grants[$];
  done_t  exp_done[$];

  task automatic push_if(input logic [31:0] a);
    exp_grants.push_back('{we: 1'b0, addr: a, wdata: 32'h0, size: 2'b10});
    exp_done.push_back('{is_dm: 1'b0, data: mem_word(a)});
  endtask

  task automatic push_dm_load(input logic [31:0] a, input logic [1:0] sz);
    exp_grants.push_back('{we: 1'b0, addr: a, wdata: 32'h0, size: sz});
    exp_done.push_back('{is_dm: 1'b1, data: mem_word(a)});
  endtask

  // Monitor: scores each new backend request and each completion pulse.
  logic        mem_req_q = 1'b0;
  logic [31:0] held_addr, held_wdata;
  logic        held_we;
  grant_t      g;
  done_t       d;
  always @(negedge CLK) begin
    if (mem_req && !mem_req_q) begin
      chk("grant_expected", 32'(exp_grants.size() > 0), 1);
      if (exp_grants.size() > 0) begin
        g = exp_grants.pop_front();
        chk("grant_addr", mem_addr, g.addr);
        chk("grant_we", 32'(mem_we), 32'(g.we));
        chk("grant_size", 32'(mem_size), 32'(g.size));
        if (g.we) chk("grant_wdata", mem_wdata, g.wdata);
      end
      held_addr  <= mem_addr;
      held_wdata <= mem_wdata;
      held_we    <= mem_we;
    end else if (mem_req && mem_req_q) begin
      chk("hold_addr", mem_addr, held_addr);
      chk("hold_we", 32'(mem_we), 32'(held_we));
      chk("hold_wdata", mem_wdata, held_wdata);
    end
    if (if_valid || dm_valid) begin
      chk("done_expected", 32'(exp_done.size() > 0), 1);
      if (exp_done.size() > 0) begin
        d = exp_done.pop_front();
        chk("done_is_dm", 32'(dm_valid), 32'(d.is_dm));
        if (if_valid) chk("if_rdata", if_rdata, d.data);
        if (dm_valid) chk("dm_rdata", dm_rdata, d.data);
      end
    end
    mem_req_q <= mem_req;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_valid(input string tag, input bit want_dm, input int budget);
    int n = 0;
    while (!(want_dm ? dm_valid : if_valid) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, 32'(n < budget), 1);
  endtask

  task automatic wait_n_valids(input string tag, input int count, input int budget);
    int seen = 0;
    int n = 0;
    while (seen < count && n < budget) begin
      @(negedge CLK);
      n++;
      if (if_valid || dm_valid) seen++;
    end
    chk(tag, 32'(seen), 32'(count));
  endtask

  logic [31:0] dm_rdata_prev;
  int          req_cycles;

  initial begin
    RST = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_size = '0;
    tick(3);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_size", 32'(mem_size), 0);
    chk("rst_if_valid", 32'(if_valid), 0);
    chk("rst_dm_valid", 32'(dm_valid), 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    RST = 1'b0;
    tick();

    // Fetch alone, immediate ack
    if_req = 1'b1; if_addr = 32'h100;
    push_if(32'h100);
    #1 chk("t1_if_stall", 32'(if_stall), 1);
    tick();
    chk("t1_mem_req", 32'(mem_req), 1);
    tick();
    chk("t1_if_valid", 32'(if_valid), 1);
    chk("t1_if_rdata", if_rdata, 32'h13);
    chk("t1_mem_req_low", 32'(mem_req), 0);
    chk("t1_stall_released", 32'(if_stall), 0);
    if_req = 1'b0;
    tick();
    chk("t1_single_pulse", 32'(if_valid), 0);

    // Stray ack while idle must do nothing
    ack_force = 1'b1;
    tick(2);
    ack_force = 1'b0;
    chk("idle_ack_mem_req", 32'(mem_req), 0);
    chk("idle_ack_valids", 32'(if_valid | dm_valid), 0);
    chk("idle_ack_if_rdata", if_rdata, 32'h13);

    // Simultaneous requests: DM first, IF after the idle gap
    if_req = 1'b1; if_addr = 32'h100;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000; dm_size = 2'b01;
    push_dm_load(32'h2000, 2'b01);
    push_if(32'h100);
    wait_valid("t2_dm_timeout", 1'b1, 20);
    dm_req = 1'b0;
    chk("t2_if_stalled", 32'(if_stall), 1);
    tick();
    chk("t2_idle_gap", 32'(mem_req), 0);
    tick();
    chk("t2_if_granted", 32'(mem_req), 1);
    chk("t2_if_addr", mem_addr, 32'h100);
    wait_valid("t2_if_timeout", 1'b0, 20);
    if_req = 1'b0;
    tick();

    // Starvation: both held, expect DM,DM,IF,DM,DM,IF
    if_req = 1'b1; if_addr = 32'h300;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000; dm_size = 2'b10;
    for (int i = 0; i < 2; i++) begin
      push_dm_load(32'h3000, 2'b10);
      push_dm_load(32'h3000, 2'b10);
      push_if(32'h300);
    end
    wait_n_valids("t3_completions", 6, 200);
    chk("t3_last_is_if", 32'(if_valid), 1);
    if_req = 1'b0; dm_req = 1'b0;
    tick(3);
    chk("t3_no_extra_grant", 32'(mem_req), 0);
    chk("t3_grants_drained", 32'(exp_grants.size()), 0);

    // Store with three wait states
    dm_rdata_prev = dm_rdata;
    ack_delay = 3;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2004; dm_wdata = 32'hDEAD_BEEF; dm_size = 2'b10;
    exp_grants.push_back('{we: 1'b1, addr: 32'h2004, wdata: 32'hDEAD_BEEF, size: 2'b10});
    exp_done.push_back('{is_dm: 1'b1, data: dm_rdata_prev});
    req_cycles = 0;
    for (int n = 0; n < 20 && !dm_valid; n++) begin
      tick();
      if (mem_req) begin
        req_cycles++;
        chk("t4_mem_we", 32'(mem_we), 1);
        chk("t4_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      end
    end
    chk("t4_req_cycles", 32'(req_cycles), 4);
    chk("t4_dm_valid", 32'(dm_valid), 1);
    chk("t4_dm_rdata_kept", dm_rdata, dm_rdata_prev);
    dm_req = 1'b0; dm_we = 1'b0;
    ack_delay = 0;
    tick();
    chk("t4_single_pulse", 32'(dm_valid), 0);
    tick();

    // Reset during BUSY_DM, ack landing on the reset edge
    ack_delay = 5;
    if_req = 1'b1; if_addr = 32'h400;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h4000; dm_size = 2'b10;
    exp_grants.push_back('{we: 1'b0, addr: 32'h4000, wdata: 32'h0, size: 2'b10});
    tick();
    chk("t5_busy", 32'(mem_req), 1);
    RST = 1'b1;
    ack_delay = 0;
    tick();
    chk("t5_rst_mem_req", 32'(mem_req), 0);
    chk("t5_rst_no_valid", 32'(dm_valid | if_valid), 0);
    RST = 1'b0;
    // A cleared starve count means two DM grants precede the fetch
    push_dm_load(32'h4000, 2'b10);
    push_dm_load(32'h4000, 2'b10);
    push_if(32'h400);
    wait_n_valids("t5_completions", 3, 100);
    chk("t5_if_serviced", 32'(if_valid), 1);
    if_req = 1'b0; dm_req = 1'b0;
    tick(2);

    // Fetch withdrawn after grant still completes exactly once
    ack_delay = 2;
    if_req = 1'b1; if_addr = 32'h500;
    push_if(32'h500);
    tick();
    chk("t6_granted", 32'(mem_req), 1);
    if_req = 1'b0;
    #1 chk("t6_stall_low", 32'(if_stall), 0);
    wait_valid("t6_if_timeout", 1'b0, 20);
    chk("t6_if_rdata", if_rdata, mem_word(32'h500));
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("t6_idle_after", 32'(mem_req | if_valid), 0);
    end

    chk("end_grants_empty", 32'(exp_grants.size()), 0);
    chk("end_done_empty", 32'(exp_done.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
